button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_if.sv | 35 +++
 rtl/button_conditioner.sv | 93 +++++++++
 tb/tb_button_conditioner.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Button pins, debounced outputs and event-flag handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
   parameter int NUM_BTN = 4
);
   logic [NUM_BTN-1:0] buttons_raw;
   logic [NUM_BTN-1:0] event_clr;
   logic [NUM_BTN-1:0] buttons_level;
   logic [NUM_BTN-1:0] press_pulse;
   logic [NUM_BTN-1:0] event_flags;
   logic               event_any;

   modport master (
      output buttons_raw,
      output event_clr,
      input  buttons_level,
      input  press_pulse,
      input  event_flags,
      input  event_any
   );

   modport slave (
      input  buttons_raw,
      input  event_clr,
      output buttons_level,
      output press_pulse,
      output event_flags,
      output event_any
   );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-channel synchronise + debounce, press strobes, sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ACTIVE_LOW      = 1
) (
   input  wire logic           clk,
   input  wire logic           rst,
   button_conditioner_if.slave btn_if
);
   localparam int                 CNT_W      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   c_cnt_max  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic               c_released = (ACTIVE_LOW != 0);

   logic [NUM_BTN-1:0] stable_q;
   logic [NUM_BTN-1:0] stable_d;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] pulse_q;
   logic [NUM_BTN-1:0] flags_q;
   logic [NUM_BTN-1:0] flags_d;
   logic               any_q;

   genvar i;
   generate
      for (i = 0; i < NUM_BTN; i++) begin : g_chan
         logic             sync1_q;
         logic             sync2_q;
         logic             sampled;
         logic             st_q;
         logic             st_d;
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         assign sampled = sync2_q ^ c_released;

         always_comb begin
            st_d  = st_q;
            cnt_d = '0;
            if (sampled != st_q) begin
               if (cnt_q == c_cnt_max) begin
                  st_d = sampled;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_q <= c_released;
               sync2_q <= c_released;
               st_q    <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= btn_if.buttons_raw[i];
               sync2_q <= sync1_q;
               st_q    <= st_d;
               cnt_q   <= cnt_d;
            end
         end

         assign stable_q[i] = st_q;
         assign stable_d[i] = st_d;
      end
   endgenerate

   // Set takes priority over a same-edge clear so no press is ever lost.
   assign rise    = stable_d & ~stable_q;
   assign flags_d = (flags_q & ~btn_if.event_clr) | rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_q <= '0;
         flags_q <= '0;
         any_q   <= 1'b0;
      end else begin
         pulse_q <= rise;
         flags_q <= flags_d;
         any_q   <= |flags_d;
      end
   end

   assign btn_if.buttons_level = stable_q;
   assign btn_if.press_pulse   = pulse_q;
   assign btn_if.event_flags   = flags_q;
   assign btn_if.event_any     = any_q;
endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed + random stimulus against a sample-window reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
   localparam int   NUM_BTN    = 4;
   localparam int   DEB        = 4;
   localparam int   ACTIVE_LOW = 1;
   localparam logic c_rel      = 1'b1;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   button_conditioner_if #(.NUM_BTN(NUM_BTN)) bus ();

   button_conditioner #(
      .NUM_BTN         (NUM_BTN),
      .DEBOUNCE_CYCLES (DEB),
      .ACTIVE_LOW      (ACTIVE_LOW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_if (bus)
   );

   // Reference: a level flips once the last DEB pressed-samples all disagree with it.
   logic [NUM_BTN-1:0] m_p1, m_p2, m_level, m_pulse, m_flags;
   logic               m_any;
   logic [DEB-1:0]     m_win [NUM_BTN];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [NUM_BTN-1:0] nl;
      if (rst) begin
         m_p1    = {NUM_BTN{c_rel}};
         m_p2    = {NUM_BTN{c_rel}};
         m_level = '0;
         m_pulse = '0;
         m_flags = '0;
         m_any   = 1'b0;
         for (int c = 0; c < NUM_BTN; c++) m_win[c] = '0;
      end else begin
         nl = m_level;
         for (int c = 0; c < NUM_BTN; c++) begin
            m_win[c] = {m_win[c][DEB-2:0], m_p2[c] ^ c_rel};
            if (m_win[c] == {DEB{~m_level[c]}}) nl[c] = ~m_level[c];
         end
         m_pulse = nl & ~m_level;
         m_flags = (m_flags & ~bus.event_clr) | m_pulse;
         m_any   = |m_flags;
         m_level = nl;
         m_p2    = m_p1;
         m_p1    = bus.buttons_raw;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("level", 32'(bus.buttons_level), 32'(m_level));
      check_eq("pulse", 32'(bus.press_pulse),   32'(m_pulse));
      check_eq("flags", 32'(bus.event_flags),   32'(m_flags));
      check_eq("any",   32'(bus.event_any),     32'(m_any));
   endtask

   initial begin
      rst             = 1'b1;
      bus.buttons_raw = 4'b1111;
      bus.event_clr   = 4'b0000;
      step();
      step();
      check_eq("rst_level", 32'(bus.buttons_level), 32'h0);
      check_eq("rst_any",   32'(bus.event_any),     32'h0);
      rst = 1'b0;
      repeat (8) step();

      // Clean press on channel 0
      bus.buttons_raw = 4'b1110;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq("clean_early_level", 32'(bus.buttons_level), 32'h0);
      end
      step();
      check_eq("clean_level", 32'(bus.buttons_level), 32'h1);
      check_eq("clean_pulse", 32'(bus.press_pulse),   32'h1);
      check_eq("clean_flags", 32'(bus.event_flags),   32'h1);
      check_eq("clean_any",   32'(bus.event_any),     32'h1);
      step();
      check_eq("clean_pulse_end", 32'(bus.press_pulse), 32'h0);
      bus.event_clr = 4'b1111;
      step();
      bus.event_clr = 4'b0000;
      check_eq("clr_all", 32'(bus.event_flags), 32'h0);

      // Bounce on channel 1: low 3, high 1, then low held
      bus.buttons_raw = 4'b1100;
      repeat (3) step();
      bus.buttons_raw = 4'b1110;
      step();
      bus.buttons_raw = 4'b1100;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq("bounce_early_level", 32'(bus.buttons_level), 32'h1);
      end
      step();
      check_eq("bounce_level", 32'(bus.buttons_level), 32'h3);
      check_eq("bounce_pulse", 32'(bus.press_pulse),   32'h2);

      // Release of both: no pulse, flags untouched
      bus.buttons_raw = 4'b1111;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq("rel_early_level", 32'(bus.buttons_level), 32'h3);
      end
      step();
      check_eq("rel_level", 32'(bus.buttons_level), 32'h0);
      check_eq("rel_pulse", 32'(bus.press_pulse),   32'h0);
      check_eq("rel_flags", 32'(bus.event_flags),   32'h2);
      bus.event_clr = 4'b1111;
      step();
      bus.event_clr = 4'b0000;

      // Clear racing a press on channel 2
      bus.buttons_raw = 4'b1011;
      repeat (5) step();
      bus.event_clr = 4'b0100;
      step();
      check_eq("race_pulse", 32'(bus.press_pulse), 32'h4);
      check_eq("race_flags", 32'(bus.event_flags), 32'h4);
      step();
      bus.event_clr = 4'b0000;
      check_eq("race_clr_flags", 32'(bus.event_flags), 32'h0);
      check_eq("race_clr_any",   32'(bus.event_any),   32'h0);

      // Simultaneous press on all channels
      bus.buttons_raw = 4'b1111;
      repeat (8) step();
      bus.buttons_raw = 4'b0000;
      repeat (5) step();
      step();
      check_eq("multi_pulse", 32'(bus.press_pulse), 32'hF);
      check_eq("multi_flags", 32'(bus.event_flags), 32'hF);
      bus.event_clr = 4'b0101;
      step();
      bus.event_clr = 4'b0000;
      check_eq("multi_clr_flags", 32'(bus.event_flags), 32'hA);
      check_eq("multi_clr_any",   32'(bus.event_any),   32'h1);

      // Reset mid-count on channel 3
      bus.buttons_raw = 4'b1111;
      repeat (8) step();
      bus.buttons_raw = 4'b0111;
      repeat (3) step();
      rst = 1'b1;
      step();
      step();
      check_eq("midrst_level", 32'(bus.buttons_level), 32'h0);
      check_eq("midrst_flags", 32'(bus.event_flags),   32'h0);
      check_eq("midrst_any",   32'(bus.event_any),     32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq("postrst_early_level", 32'(bus.buttons_level), 32'h0);
         check_eq("postrst_early_pulse", 32'(bus.press_pulse),   32'h0);
      end
      step();
      check_eq("postrst_level", 32'(bus.buttons_level), 32'h8);
      check_eq("postrst_pulse", 32'(bus.press_pulse),   32'h8);
      step();
      check_eq("postrst_pulse_end", 32'(bus.press_pulse), 32'h0);

      // Random bouncing, clears and occasional resets
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NUM_BTN; c++)
            if ($urandom_range(0, 4) == 0) bus.buttons_raw[c] = ~bus.buttons_raw[c];
         bus.event_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         rst           = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
